// File: rtl/hmm_obs_gen.sv
// hmm_obs_gen
//   Synthetic HMM observation source. Samples a hidden state path and an
//   emission sequence from an I-state, K-symbol HMM. A 16-bit Galois LFSR
//   drives the sampling. The symbols are streamed over a valid/ready
//   handshake, and the true state path is kept for scoring a decoder.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse, accepted only while idle
//   length       number of symbols to generate (0 behaves as 1), latched on start
//   seed         LFSR seed (0 is replaced by 16'hACE1), latched on start
//   cumC         initial-state CDF thresholds [state]
//   cumA         transition CDF thresholds [from*I+to]
//   cumB         emission CDF thresholds [state*K+sym]
//   obs_out      current symbol, valid while obs_valid is high
//   obs_valid    symbol available
//   obs_ready    consumer accepts the symbol on this edge
//   state_out    hidden state that emitted obs_out
//   path         true state sequence, complete when done pulses
//   done         one-cycle pulse after the last symbol has been accepted
module hmm_obs_gen #(
  parameter int N = 8,
  parameter int I = 3,
  parameter int K = 3,
  localparam int LW = $clog2(N),
  localparam int SW = $clog2(I),
  localparam int OW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] length,
  input  logic [15:0]   seed,
  input  logic [15:0]   cumC [0:I-1],
  input  logic [15:0]   cumA [0:I*I-1],
  input  logic [15:0]   cumB [0:I*K-1],
  output logic [OW-1:0] obs_out,
  output logic          obs_valid,
  input  logic          obs_ready,
  output logic [SW-1:0] state_out,
  output logic [SW-1:0] path [0:N-1],
  output logic          done
);

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_OBS,
    S_SEND,
    S_TRANS,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [15:0]   lfsr_reg, lfsr_next, lfsr_step;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] t_reg, t_next;
  logic [SW-1:0] st_reg, st_next;
  logic [OW-1:0] obs_reg, obs_next;
  logic          path_we;
  logic [SW-1:0] path_reg [0:N-1];

  logic [SW-1:0] init_pick;
  logic [SW-1:0] trans_pick;
  logic [OW-1:0] emit_pick;

  // Galois right-shift step; the LFSR never reaches zero from a nonzero seed.
  assign lfsr_step = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

  // Each sampler returns the smallest j < n-1 with r <= row[j], else n-1.
  // The scan runs downward so the lowest matching index wins. The last
  // threshold of a row is never consulted.
  always_comb begin
    init_pick = SW'(I - 1);
    for (int j = I - 2; j >= 0; j--) begin
      if (lfsr_reg <= cumC[j]) init_pick = SW'(j);
    end
  end

  always_comb begin
    trans_pick = SW'(I - 1);
    for (int j = I - 2; j >= 0; j--) begin
      if (lfsr_reg <= cumA[int'(st_reg) * I + j]) trans_pick = SW'(j);
    end
  end

  always_comb begin
    emit_pick = OW'(K - 1);
    for (int j = K - 2; j >= 0; j--) begin
      if (lfsr_reg <= cumB[int'(st_reg) * K + j]) emit_pick = OW'(j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      lfsr_reg  <= LFSR_DEFAULT;
      len_reg   <= '0;
      t_reg     <= '0;
      st_reg    <= '0;
      obs_reg   <= '0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      len_reg   <= len_next;
      t_reg     <= t_next;
      st_reg    <= st_next;
      obs_reg   <= obs_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    len_next   = len_reg;
    t_next     = t_reg;
    st_next    = st_reg;
    obs_next   = obs_reg;
    path_we    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          lfsr_next  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
          len_next   = (length == '0) ? LW'(1) : length;
          t_next     = '0;
          state_next = S_INIT;
        end
      end
      S_INIT: begin
        st_next    = init_pick;
        lfsr_next  = lfsr_step;
        state_next = S_OBS;
      end
      S_OBS: begin
        obs_next   = emit_pick;
        path_we    = 1'b1;
        lfsr_next  = lfsr_step;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (obs_ready) begin
          if (t_reg == len_reg - LW'(1)) begin
            state_next = S_DONE;
          end else begin
            t_next     = t_reg + LW'(1);
            state_next = S_TRANS;
          end
        end
      end
      S_TRANS: begin
        st_next    = trans_pick;
        lfsr_next  = lfsr_step;
        state_next = S_OBS;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Path slots are written only at index t. Slots beyond the current
  // length keep whatever an earlier run left in them.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_path
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          path_reg[gi] <= '0;
        end else if (path_we && (t_reg == LW'(gi))) begin
          path_reg[gi] <= st_reg;
        end
      end
      assign path[gi] = path_reg[gi];
    end
  endgenerate

  // Handshake outputs decode the state register directly, so reset clears
  // them without waiting for a clock edge.
  assign obs_valid = (state_reg == S_SEND);
  assign done      = (state_reg == S_DONE);
  assign obs_out   = obs_reg;
  assign state_out = st_reg;

endmodule

// File: tb/tb_hmm_obs_gen.sv
module tb_hmm_obs_gen;

  localparam int N = 8;
  localparam int I = 3;
  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  length = 3'd0;
  logic [15:0] seed = 16'h0000;
  logic [15:0] cumC [0:I-1];
  logic [15:0] cumA [0:I*I-1];
  logic [15:0] cumB [0:I*K-1];
  logic [1:0]  obs_out;
  logic        obs_valid;
  logic        obs_ready = 1'b1;
  logic [1:0]  state_out;
  logic [1:0]  path [0:N-1];
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  // Monitor results of the most recent run
  int         xfer_n;
  logic [1:0] xfer_obs [0:15];
  logic [1:0] xfer_st  [0:15];
  int         xfer_cyc [0:15];
  int         done_cyc;
  int         unstable;

  hmm_obs_gen #(.N(N), .I(I), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .length    (length),
    .seed      (seed),
    .cumC      (cumC),
    .cumA      (cumA),
    .cumB      (cumB),
    .obs_out   (obs_out),
    .obs_valid (obs_valid),
    .obs_ready (obs_ready),
    .state_out (state_out),
    .path      (path),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Forces 0 -> 1 -> 2 -> 0 and emits symbol == state.
  task automatic set_cyclic();
    cumC[0] = 16'hFFFF; cumC[1] = 16'h0000; cumC[2] = 16'h0000;
    cumA[0] = 16'h0000; cumA[1] = 16'hFFFF; cumA[2] = 16'h0000;
    cumA[3] = 16'h0000; cumA[4] = 16'h0000; cumA[5] = 16'h0000;
    cumA[6] = 16'hFFFF; cumA[7] = 16'h0000; cumA[8] = 16'h0000;
    cumB[0] = 16'hFFFF; cumB[1] = 16'h0000; cumB[2] = 16'h0000;
    cumB[3] = 16'h0000; cumB[4] = 16'hFFFF; cumB[5] = 16'h0000;
    cumB[6] = 16'h0000; cumB[7] = 16'h0000; cumB[8] = 16'h0000;
  endtask

  // Threshold test tables: state 0 iff r <= 8000, symbol 0 iff r <= 8000.
  task automatic set_threshold();
    set_cyclic();
    cumC[0] = 16'h8000; cumC[1] = 16'h0000;
    cumB[0] = 16'h8000; cumB[1] = 16'h0000;
  endtask

  // Drives one run and records every transfer. Sample index 0 is the
  // cycle right after the edge that accepted start. bp_sym/bp_len hold
  // obs_ready low for bp_len cycles on that symbol. poke re-asserts start
  // (with a different length) while the generator is busy.
  task automatic run(input int ln, input logic [15:0] sd, input int bp_sym,
                     input int bp_len, input bit poke, input int max_cyc);
    int bp_left;
    bit holding;
    logic [1:0] h_obs, h_st;
    xfer_n   = 0;
    done_cyc = -1;
    unstable = 0;
    bp_left  = bp_len;
    holding  = 1'b0;
    h_obs    = 2'd0;
    h_st     = 2'd0;
    @(posedge clk); #1;
    length = ln[2:0]; seed = sd; start = 1'b1; obs_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cycle = 0; cycle < max_cyc; cycle++) begin
      if (done) begin
        done_cyc = cycle;
        break;
      end
      obs_ready = 1'b1;
      start     = 1'b0;
      length    = ln[2:0];
      if (obs_valid) begin
        if (holding && (obs_out !== h_obs || state_out !== h_st)) unstable++;
        if (xfer_n == bp_sym && bp_left > 0) begin
          if (!holding) begin
            h_obs   = obs_out;
            h_st    = state_out;
            holding = 1'b1;
          end
          obs_ready = 1'b0;
          bp_left--;
        end else begin
          holding = 1'b0;
          if (xfer_n < 16) begin
            xfer_obs[xfer_n] = obs_out;
            xfer_st[xfer_n]  = state_out;
            xfer_cyc[xfer_n] = cycle;
          end
          $display("xfer %0d obs=%0d state=%0d cycle=%0d", xfer_n, obs_out, state_out, cycle);
          xfer_n++;
          if (poke && xfer_n == 2) begin
            start  = 1'b1;
            length = 3'd7;
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if (obs_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got valid=%b done=%b expected 0 0", obs_valid, done);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs_out !== 2'd0 || state_out !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_data: got obs=%0d state=%0d expected 0 0", obs_out, state_out);
    end
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (path[k] !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_path[%0d]: got %0d expected 0", k, path[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cyclic();
    set_cyclic();
    run(5, 16'h1234, -1, 0, 1'b0, 100);
    vectors++;
    if (done_cyc < 0 || xfer_n !== 5) begin
      miscompares++;
      $display("FAIL cyc_count: got xfers=%0d done_cyc=%0d expected 5 and done", xfer_n, done_cyc);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (xfer_obs[k] !== 2'(k % 3) || xfer_st[k] !== 2'(k % 3) || xfer_cyc[k] !== 2 + 3 * k) begin
        miscompares++;
        $display("FAIL cyc_xfer[%0d]: got obs=%0d st=%0d cyc=%0d expected %0d %0d %0d",
                 k, xfer_obs[k], xfer_st[k], xfer_cyc[k], k % 3, k % 3, 2 + 3 * k);
      end
      vectors++;
      if (path[k] !== 2'(k % 3)) begin
        miscompares++;
        $display("FAIL cyc_path[%0d]: got %0d expected %0d", k, path[k], k % 3);
      end
    end
    vectors++;
    if (done_cyc !== 15) begin
      miscompares++;
      $display("FAIL cyc_done_time: got %0d expected 15", done_cyc);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || obs_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cyc_done_pulse: got done=%b valid=%b expected 0 0", done, obs_valid);
    end
  endtask

  task automatic test_lfsr_threshold();
    set_threshold();
    run(1, 16'h0001, -1, 0, 1'b0, 50);
    vectors++;
    if (xfer_n !== 1 || done_cyc !== 3) begin
      miscompares++;
      $display("FAIL thr_count: got xfers=%0d done_cyc=%0d expected 1 3", xfer_n, done_cyc);
    end
    vectors++;
    if (xfer_st[0] !== 2'd0 || xfer_obs[0] !== 2'd2) begin
      miscompares++;
      $display("FAIL thr_sample: got st=%0d obs=%0d expected 0 2", xfer_st[0], xfer_obs[0]);
    end
    vectors++;
    if (path[0] !== 2'd0) begin
      miscompares++;
      $display("FAIL thr_path0: got %0d expected 0", path[0]);
    end
    // Slots beyond length keep the previous run's values.
    for (int k = 1; k < 5; k++) begin
      vectors++;
      if (path[k] !== 2'(k % 3)) begin
        miscompares++;
        $display("FAIL thr_path_keep[%0d]: got %0d expected %0d", k, path[k], k % 3);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_cyc [0:4];
    exp_cyc[0] = 2; exp_cyc[1] = 9; exp_cyc[2] = 12; exp_cyc[3] = 15; exp_cyc[4] = 18;
    set_cyclic();
    run(5, 16'h5A5A, 1, 4, 1'b0, 100);
    vectors++;
    if (xfer_n !== 5 || done_cyc !== 19) begin
      miscompares++;
      $display("FAIL bp_count: got xfers=%0d done_cyc=%0d expected 5 19", xfer_n, done_cyc);
    end
    vectors++;
    if (unstable !== 0) begin
      miscompares++;
      $display("FAIL bp_stable: got %0d changes while held expected 0", unstable);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (xfer_obs[k] !== 2'(k % 3) || xfer_st[k] !== 2'(k % 3) || xfer_cyc[k] !== exp_cyc[k]) begin
        miscompares++;
        $display("FAIL bp_xfer[%0d]: got obs=%0d st=%0d cyc=%0d expected %0d %0d %0d",
                 k, xfer_obs[k], xfer_st[k], xfer_cyc[k], k % 3, k % 3, exp_cyc[k]);
      end
      vectors++;
      if (path[k] !== 2'(k % 3)) begin
        miscompares++;
        $display("FAIL bp_path[%0d]: got %0d expected %0d", k, path[k], k % 3);
      end
    end
  endtask

  // r = ACE1 > ACE0 picks state 2; next r = E270 lies in (E26F, FFFF] -> symbol 1.
  task automatic test_zero_seed_len();
    set_cyclic();
    cumC[0] = 16'hACE0; cumC[1] = 16'h0000;
    cumB[6] = 16'hE26F; cumB[7] = 16'hFFFF;
    run(0, 16'h0000, -1, 0, 1'b0, 50);
    vectors++;
    if (xfer_n !== 1 || done_cyc !== 3) begin
      miscompares++;
      $display("FAIL zero_count: got xfers=%0d done_cyc=%0d expected 1 3", xfer_n, done_cyc);
    end
    vectors++;
    if (xfer_st[0] !== 2'd2 || xfer_obs[0] !== 2'd1) begin
      miscompares++;
      $display("FAIL zero_sample: got st=%0d obs=%0d expected 2 1", xfer_st[0], xfer_obs[0]);
    end
    vectors++;
    if (path[0] !== 2'd2 || path[1] !== 2'd1) begin
      miscompares++;
      $display("FAIL zero_path: got %0d %0d expected 2 1", path[0], path[1]);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || obs_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after: got done=%b valid=%b expected 0 0", done, obs_valid);
    end
  endtask

  task automatic test_start_ignored();
    set_cyclic();
    run(5, 16'h0F0F, -1, 0, 1'b1, 100);
    vectors++;
    if (xfer_n !== 5 || done_cyc !== 15) begin
      miscompares++;
      $display("FAIL busy_start_count: got xfers=%0d done_cyc=%0d expected 5 15", xfer_n, done_cyc);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (xfer_obs[k] !== 2'(k % 3) || xfer_cyc[k] !== 2 + 3 * k) begin
        miscompares++;
        $display("FAIL busy_start_xfer[%0d]: got obs=%0d cyc=%0d expected %0d %0d",
                 k, xfer_obs[k], xfer_cyc[k], k % 3, 2 + 3 * k);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int sends;
    logic prev_valid;
    set_cyclic();
    sends = 0;
    prev_valid = 1'b0;
    @(posedge clk); #1;
    length = 3'd5; seed = 16'h1234; start = 1'b1; obs_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (obs_valid && !prev_valid) sends++;
      if (sends == 3) break;
      prev_valid = obs_valid;
      @(posedge clk); #1;
    end
    vectors++;
    if (sends !== 3 || obs_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reach_send: got sends=%0d valid=%b expected 3 1", sends, obs_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%b done=%b expected 0 0", obs_valid, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(5, 16'h1234, -1, 0, 1'b0, 100);
    vectors++;
    if (xfer_n !== 5 || done_cyc !== 15) begin
      miscompares++;
      $display("FAIL rst_rerun_count: got xfers=%0d done_cyc=%0d expected 5 15", xfer_n, done_cyc);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (xfer_obs[k] !== 2'(k % 3) || xfer_st[k] !== 2'(k % 3) || path[k] !== 2'(k % 3)) begin
        miscompares++;
        $display("FAIL rst_rerun[%0d]: got obs=%0d st=%0d path=%0d expected %0d",
                 k, xfer_obs[k], xfer_st[k], path[k], k % 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_threshold();
    run(1, 16'h0001, -1, 0, 1'b0, 50);
    vectors++;
    if (xfer_n !== 1 || xfer_obs[0] !== 2'd2 || done_cyc !== 3) begin
      miscompares++;
      $display("FAIL b2b_first: got xfers=%0d obs=%0d done_cyc=%0d expected 1 2 3",
               xfer_n, xfer_obs[0], done_cyc);
    end
    // Next start is raised in the IDLE cycle right after done.
    set_cyclic();
    run(4, 16'hBEEF, -1, 0, 1'b0, 100);
    vectors++;
    if (xfer_n !== 4 || done_cyc !== 12) begin
      miscompares++;
      $display("FAIL b2b_second_count: got xfers=%0d done_cyc=%0d expected 4 12", xfer_n, done_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (xfer_obs[k] !== 2'(k % 3) || xfer_cyc[k] !== 2 + 3 * k) begin
        miscompares++;
        $display("FAIL b2b_second_xfer[%0d]: got obs=%0d cyc=%0d expected %0d %0d",
                 k, xfer_obs[k], xfer_cyc[k], k % 3, 2 + 3 * k);
      end
    end
  endtask

  initial begin
    set_cyclic();
    test_reset();
    test_cyclic();
    test_lfsr_threshold();
    test_backpressure();
    test_zero_seed_len();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
